// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 stream mux with round-robin or fixed select and a registered one-word output stage.
module stream_mux_rr #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           fixed,
  input  logic [SW-1:0]  fixed_sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);
  logic [SW-1:0] ptr, rr_idx, idx, gnt;
  logic [W-1:0]  gnt_data;
  logic          rr_hit, fx_hit, gnt_hit, space, xfer;
  assign space   = !out_valid || out_ready;
  assign fx_hit  = (int'(fixed_sel) < N) && in_valid[fixed_sel];
  assign gnt_hit = fixed ? fx_hit : rr_hit;
  assign gnt     = fixed ? fixed_sel : rr_idx;
  // reset gates the handshake so no word is accepted while the stage is being cleared
  assign xfer    = !rst && gnt_hit && space;
  // descending scan so the channel closest after ptr is the last (winning) assignment
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SW'((int'(ptr) + k) % N);
      if (in_valid[idx]) begin
        rr_hit = 1'b1;
        rr_idx = idx;
      end
    end
  end
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      gnt_data    = (gnt == SW'(i)) ? in_data[i*W +: W] : gnt_data;
      in_ready[i] = xfer && (gnt == SW'(i));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt;
      ptr       <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table-driven check of stream_mux_rr with an output-word scoreboard.
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data;
  logic [3:0]  in_valid, in_ready, out_data;
  logic        fixed, out_valid, out_ready;
  logic [1:0]  fixed_sel, out_sel;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0]  iv;
    logic [15:0] id;
    logic        fx;
    logic [1:0]  fs;
    logic        ordy;
    logic [3:0]  er;
    logic        ev;
    logic [1:0]  es;
    logic [3:0]  ed;
  } vec_t;
  vec_t vt[$];
  logic [5:0] sb[$];
  always #5 clk = ~clk;
  stream_mux_rr #(.W(4), .N(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fixed(fixed), .fixed_sel(fixed_sel), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    int s;
    logic [5:0] w;
    in_valid = 4'hF; in_data = 16'hDCBA; fixed = 1'b0; fixed_sel = 2'd0; out_ready = 1'b1;
    vt.push_back('{4'hF, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 4'hA});
    vt.push_back('{4'hF, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 4'hB});
    vt.push_back('{4'hF, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 4'hC});
    vt.push_back('{4'hF, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
    vt.push_back('{4'hF, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 4'hA});
    vt.push_back('{4'h9, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
    vt.push_back('{4'h9, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 4'hA});
    vt.push_back('{4'h9, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
    vt.push_back('{4'h9, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 4'hA});
    vt.push_back('{4'h0, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 4'hA});
    vt.push_back('{4'h0, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 4'hA});
    vt.push_back('{4'h4, 16'h6512, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 4'h5});
    vt.push_back('{4'hC, 16'h6512, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 4'h5});
    vt.push_back('{4'hC, 16'h6512, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 4'h5});
    vt.push_back('{4'hC, 16'h6512, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd2, 4'h5});
    vt.push_back('{4'hC, 16'h6512, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 4'h6});
    vt.push_back('{4'hF, 16'hDCBA, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 4'hC});
    vt.push_back('{4'hF, 16'hDCBA, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 4'hC});
    vt.push_back('{4'hF, 16'hDCBA, 1'b0, 2'd2, 1'b1, 4'h8, 1'b1, 2'd3, 4'hD});
    vt.push_back('{4'hD, 16'hDCBA, 1'b1, 2'd1, 1'b1, 4'h0, 1'b0, 2'd3, 4'hD});
    vt.push_back('{4'h6, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 4'hB});
    vt.push_back('{4'hF, 16'hDCBA, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 2'd1, 4'hB});
    vt.push_back('{4'h0, 16'hDCBA, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd1, 4'hB});
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (vt[n]) begin
      in_valid = vt[n].iv; in_data = vt[n].id; fixed = vt[n].fx;
      fixed_sel = vt[n].fs; out_ready = vt[n].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", n), in_ready, vt[n].er);
      if (out_valid && out_ready) begin
        chk($sformatf("v%0d_sb_nonempty", n), sb.size() != 0, 1);
        if (sb.size() != 0) begin
          w = sb.pop_front();
          chk($sformatf("v%0d_sb_word", n), {out_sel, out_data}, w);
        end
      end
      if (vt[n].er != 4'h0) begin
        s = 0;
        for (int k = 0; k < 4; k++) if (vt[n].er[k]) s = k;
        sb.push_back({2'(s), vt[n].id[s*4 +: 4]});
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", n), out_valid, vt[n].ev);
      chk($sformatf("v%0d_out_sel", n), out_sel, vt[n].es);
      chk($sformatf("v%0d_out_data", n), out_data, vt[n].ed);
    end
    chk("sb_empty", sb.size(), 0);
    in_valid = 4'h4; in_data = 16'hDCBA; fixed = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sel", out_sel, 2);
    chk("pre_rst_data", out_data, 4'hC);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_sel", out_sel, 0);
    chk("async_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 4'h1);
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_sel", out_sel, 0);
    chk("post_rst_data", out_data, 4'hA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter W, default 4, width in bits of each data channel (W >= 1).
REQ-002 Parameter N, default 4, number of input channels (N >= 2); SW = $clog2(N).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_data  input  N*W  channel i data at bits [i*W +: W].
REQ-006 in_valid  input  N  channel i offers a word.
REQ-007 in_ready  output  N  channel i word accepted this cycle when in_valid[i] and in_ready[i] are both 1.
REQ-008 fixed  input  1  1 = fixed-select mode, 0 = round-robin mode.
REQ-009 fixed_sel  input  SW  channel served in fixed-select mode.
REQ-010 out_data  output  W  registered output word.
REQ-011 out_sel  output  SW  registered index of the channel that supplied out_data.
REQ-012 out_valid  output  1  out_data/out_sel hold a word.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both 1.

Function
REQ-014 The block SHALL hold one output register (out_data, out_sel, out_valid); "space" = !out_valid || out_ready.
REQ-015 Grant SHALL be combinational from in_valid, fixed, fixed_sel and pointer ptr (SW bits).
REQ-016 Round-robin: grant = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... mod N; no grant if in_valid == 0.
REQ-017 Fixed mode: grant = fixed_sel if in_valid[fixed_sel]=1, else no grant; other channels SHALL see in_ready=0.
REQ-018 fixed_sel >= N (non-power-of-2 N) SHALL produce no grant.
REQ-019 in_ready[i] SHALL be 1 only when i is granted and space = 1; at most one bit of in_ready SHALL be 1.
REQ-020 in_ready SHALL NOT depend on in_valid of the granted channel other than through grant selection (no combinational loop through in_ready).
REQ-021 On a transfer from channel g: next cycle out_data = channel g data, out_sel = g, out_valid = 1, ptr = g.
REQ-022 Latency input-to-output SHALL be exactly 1 cycle; sustained throughput SHALL be 1 word per cycle when out_ready is held 1.
REQ-023 Output drained (out_valid & out_ready) with no new transfer: next cycle out_valid = 0; out_data/out_sel hold.
REQ-024 out_valid=1, out_ready=0: out_data, out_sel, out_valid and ptr SHALL hold; all in_ready = 0.
REQ-025 Simultaneous drain and accept in one cycle SHALL replace the word without a bubble.
REQ-026 ptr SHALL change only on a transfer, in both modes; switching fixed mid-stream SHALL take effect in the same cycle's grant.
REQ-027 Wrap-around: with ptr = N-1 search SHALL start at channel 0.

Reset
REQ-028 While rst = 1: out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1, all in_ready = 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held word immediately (asynchronously), without waiting for clk.
REQ-030 First cycle after rst deasserts, round-robin search SHALL start at channel 0.

Verification (W=4, N=4)
REQ-031 Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 before next clk edge.
REQ-032 Fairness: in_valid=4'b1111, data {d0..d3}={a,b,c,d}, out_ready=1 -> out_sel sequence 0,1,2,3,0,... out_data a,b,c,d,a, one per cycle.
REQ-033 Sparse/wrap: in_valid=4'b1001 held, out_ready=1 -> out_sel alternates 0,3,0,3.
REQ-034 Backpressure: out_valid=1 with word 5 from ch2, out_ready=0 for 3 cycles -> out_data=5, out_sel=2 stable, in_ready=0; on out_ready=1 next word from ch3 with no bubble.
REQ-035 Fixed mode: fixed=1, fixed_sel=2, in_valid=4'b1111 -> only in_ready[2]=1, out_sel=2 every cycle; fixed=0 next -> next grant channel 3.
REQ-036 Empty: in_valid=0, out_ready=1 after one word -> out_valid falls to 0 one cycle after drain, out_data holds last value.
